uart_rx_ovs: RTL

//  Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds configurable

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_tick.sv | 21 ++
 rtl/uart_rx_ovs.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, baud divider computation and oversampling legality check.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  function automatic int baud_div(input int clk_hz, input int bps, input int ovs);
    return (clk_hz + bps * ovs / 2) / (bps * ovs);
  endfunction
  function automatic bit ovs_ok(input int ovs);
    return ovs == 8 || ovs == 16;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-clk tick every DIV clks, phase restartable by a synchronous restart input.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= !restart && cnt == LAST;
      cnt  <= (restart || cnt == LAST) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with majority vote, parity/framing/break/overrun flags.
module uart_rx_ovs import uart_pkg::*; #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);
  localparam int DIV = baud_div(CLK_FREQ, UART_BPS, OVS);
  localparam int SW = $clog2(OVS);
  localparam parity_t PAR = parity_t'(PARITY);
  localparam logic [SW-1:0] S_LO  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVS / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);
  localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] P_LAST = 4'(STOP_BITS - 1);
  if (!ovs_ok(OVS)) begin : g_bad_ovs
    $error("uart_rx_ovs: OVS must be 8 or 16");
  end
  logic s1, rx_s, rx_d, tick, start_edge, vote, perr;
  logic done, par_bit, ferr, any1;
  logic [1:0] v;
  logic [SW-1:0] smp;
  logic [3:0] bit_cnt;
  logic [DATA_BITS-1:0] sh;
  rx_state_t state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
      rx_d <= rx_s;
    end
  // a falling edge can only follow a high level, so a held break never restarts reception
  assign start_edge = state == IDLE && rx_d && !rx_s;
  assign vote = (v[0] & v[1]) | (rx_s & (v[0] | v[1]));
  assign perr = PAR == PAR_ODD ? par_bit == ^sh : PAR == PAR_EVEN ? par_bit != ^sh : 1'b0;
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .restart(start_edge),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      smp     <= '0;
      bit_cnt <= '0;
      v       <= '0;
      sh      <= '0;
      par_bit <= 1'b0;
      ferr    <= 1'b0;
      any1    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_edge) begin
        state   <= START;
        smp     <= '0;
        bit_cnt <= '0;
        ferr    <= 1'b0;
        any1    <= 1'b0;
      end else if (tick && state != IDLE) begin
        smp <= smp + 1'b1;
        if (smp == S_LO) v[0] <= rx_s;
        if (smp == S_MID) v[1] <= rx_s;
        if (smp == S_HI)
          case (state)
            START: if (vote) state <= IDLE;
            DATA: begin
              sh   <= {vote, sh[DATA_BITS-1:1]};
              any1 <= any1 | vote;
            end
            uart_pkg::PARITY: begin
              par_bit <= vote;
              any1    <= any1 | vote;
            end
            STOP: begin
              ferr <= ferr | ~vote;
              any1 <= any1 | vote;
              if (bit_cnt == P_LAST) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
            default: ;
          endcase
        if (smp == S_END)
          case (state)
            START: state <= DATA;
            DATA: begin
              bit_cnt <= bit_cnt == D_LAST ? '0 : bit_cnt + 1'b1;
              if (bit_cnt == D_LAST) state <= PAR == PAR_NONE ? STOP : uart_pkg::PARITY;
            end
            uart_pkg::PARITY: state <= STOP;
            STOP: bit_cnt <= bit_cnt + 1'b1;
            default: ;
          endcase
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data    <= sh;
        parity_err <= perr;
        frame_err  <= ferr;
        break_det  <= ~any1;
        rx_valid   <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule
